// File: rtl/sequence_generator_if.sv
// Load handshake and serial output bundle for sequence_generator.
interface sequence_generator_if #(
  parameter int DATA_W = 8
);
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic [3:0]        repeat_cnt;
  logic              load_ready;
  logic              sequence_out;
  logic              out_valid;
  logic              done;

  modport master (
    output load_valid, load_data, repeat_cnt,
    input  load_ready, sequence_out, out_valid, done
  );

  modport slave (
    input  load_valid, load_data, repeat_cnt,
    output load_ready, sequence_out, out_valid, done
  );
endinterface

// File: rtl/sequence_generator.sv
// Serial MSB-first word transmitter with repeat count; define SEQ_GEN_PREAMBLE_EN
// to prefix every repetition with the detector trigger PATTERN.
module sequence_generator #(
  parameter int         DATA_W  = 8,
  parameter int         PAT_W   = 4,
  parameter logic [7:0] PATTERN = 8'b0000_1011
) (
  input  logic                 clk,
  input  logic                 reset,
  sequence_generator_if.slave  bus
);

  localparam int MAX_W = (DATA_W > PAT_W) ? DATA_W : PAT_W;
  localparam int CNT_W = $clog2(MAX_W);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

  if (DATA_W < 2 || DATA_W > 32 || PAT_W < 1 || PAT_W > 8 ||
      (PATTERN >> PAT_W) != 8'd0) begin : g_bad_cfg
    $error("sequence_generator: illegal DATA_W/PAT_W/PATTERN");
  end

`ifdef SEQ_GEN_PREAMBLE_EN
  localparam logic [CNT_W-1:0] PAT_LAST = CNT_W'(PAT_W - 1);
  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA} state_e;
`else
  typedef enum logic [1:0] {IDLE, DATA} state_e;
`endif

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_m1;
  logic [3:0]        rep_q, rep_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              seq_q, seq_d;
  logic              vld_q, vld_d;
  logic              done_q, done_d;
  logic              data_bit;

  // Outputs are registered for the bit that is on the wire next cycle.
  assign cnt_m1   = cnt_q - 1'b1;
  assign data_bit = |(data_q & (DATA_W'(1) << cnt_m1));
`ifdef SEQ_GEN_PREAMBLE_EN
  logic pat_bit;
  assign pat_bit  = |(PATTERN & (8'd1 << cnt_m1));
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rep_d   = rep_q;
    data_d  = data_q;
    seq_d   = 1'b0;
    vld_d   = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.load_valid) begin
          data_d = bus.load_data;
          rep_d  = bus.repeat_cnt;
          vld_d  = 1'b1;
`ifdef SEQ_GEN_PREAMBLE_EN
          state_d = PREAMBLE;
          cnt_d   = PAT_LAST;
          seq_d   = PATTERN[PAT_W-1];
`else
          state_d = DATA;
          cnt_d   = DATA_LAST;
          seq_d   = bus.load_data[DATA_W-1];
`endif
        end
      end
`ifdef SEQ_GEN_PREAMBLE_EN
      PREAMBLE: begin
        vld_d = 1'b1;
        if (cnt_q == '0) begin
          state_d = DATA;
          cnt_d   = DATA_LAST;
          seq_d   = data_q[DATA_W-1];
        end else begin
          cnt_d = cnt_m1;
          seq_d = pat_bit;
        end
      end
`endif
      DATA: begin
        if (cnt_q != '0) begin
          vld_d = 1'b1;
          cnt_d = cnt_m1;
          seq_d = data_bit;
        end else if (rep_q != 4'd0) begin
          // Next repetition starts immediately with the same latched word.
          rep_d = rep_q - 4'd1;
          vld_d = 1'b1;
`ifdef SEQ_GEN_PREAMBLE_EN
          state_d = PREAMBLE;
          cnt_d   = PAT_LAST;
          seq_d   = PATTERN[PAT_W-1];
`else
          cnt_d   = DATA_LAST;
          seq_d   = data_q[DATA_W-1];
`endif
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rep_q   <= '0;
      data_q  <= '0;
      seq_q   <= 1'b0;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rep_q   <= rep_d;
      data_q  <= data_d;
      seq_q   <= seq_d;
      vld_q   <= vld_d;
      done_q  <= done_d;
    end
  end

  assign bus.load_ready   = (state_q == IDLE);
  assign bus.sequence_out = seq_q & vld_q;
  assign bus.out_valid    = vld_q;
  assign bus.done         = done_q;

endmodule

// File: tb/tb_sequence_generator.sv
// Directed self-checking bench for sequence_generator (both preamble builds).
module tb_sequence_generator;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  sequence_generator_if #(.DATA_W(8)) bus ();

  sequence_generator #(.DATA_W(8), .PAT_W(4), .PATTERN(8'b0000_1011)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

`ifdef SEQ_GEN_PREAMBLE_EN
  localparam int          FW     = 12;
  localparam logic [11:0] EXP_A5 = 12'b1011_1010_0101;
  localparam int          DET_A5 = 1;
  function automatic logic [11:0] frame(input logic [7:0] w);
    return {4'b1011, w};
  endfunction
`else
  localparam int          FW     = 8;
  localparam logic [11:0] EXP_A5 = 12'b0000_1010_0101;
  localparam int          DET_A5 = 0;
  function automatic logic [11:0] frame(input logic [7:0] w);
    return {4'b0000, w};
  endfunction
`endif

  task automatic test_reset;
    reset = 1'b1;
    bus.load_valid = 1'b0;
    bus.load_data  = 8'h00;
    bus.repeat_cnt = 4'd0;
    repeat (3) begin
      @(negedge clk);
      total++;
      if ({bus.load_ready, bus.out_valid, bus.sequence_out, bus.done} !== 4'b1000) begin
        bad++;
        $display("FAIL reset_hold: got rdy/vld/seq/done=%b want 1000",
                 {bus.load_ready, bus.out_valid, bus.sequence_out, bus.done});
      end
    end
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      total++;
      if ({bus.load_ready, bus.out_valid, bus.sequence_out, bus.done} !== 4'b1000) begin
        bad++;
        $display("FAIL reset_idle: got rdy/vld/seq/done=%b want 1000",
                 {bus.load_ready, bus.out_valid, bus.sequence_out, bus.done});
      end
    end
  endtask

  task automatic test_single;
    logic [11:0] exp;
    logic [3:0]  win;
    int          det;
    exp = EXP_A5;
    win = 4'b0;
    det = 0;
    bus.load_valid = 1'b1;
    bus.load_data  = 8'hA5;
    bus.repeat_cnt = 4'd0;
    @(negedge clk);
    bus.load_valid = 1'b0;
    for (int i = 0; i < FW; i++) begin
      total++;
      if (bus.out_valid !== 1'b1 || bus.sequence_out !== exp[FW-1-i] ||
          bus.done !== 1'b0 || bus.load_ready !== 1'b0) begin
        bad++;
        $display("FAIL a5_bit%0d: got vld=%b seq=%b done=%b rdy=%b want 1 %b 0 0",
                 i, bus.out_valid, bus.sequence_out, bus.done, bus.load_ready, exp[FW-1-i]);
      end
      win = {win[2:0], bus.sequence_out};
      if (i >= 3 && win == 4'b1011) det++;
      @(negedge clk);
    end
    total++;
    if ({bus.load_ready, bus.out_valid, bus.sequence_out, bus.done} !== 4'b1001) begin
      bad++;
      $display("FAIL a5_done: got rdy/vld/seq/done=%b want 1001",
               {bus.load_ready, bus.out_valid, bus.sequence_out, bus.done});
    end
    @(negedge clk);
    total++;
    if ({bus.load_ready, bus.out_valid, bus.done} !== 3'b100) begin
      bad++;
      $display("FAIL a5_after: got rdy/vld/done=%b want 100",
               {bus.load_ready, bus.out_valid, bus.done});
    end
    total++;
    if (det !== DET_A5) begin
      bad++;
      $display("FAIL a5_detect: got %0d detections want %0d", det, DET_A5);
    end
  endtask

  task automatic test_repeat;
    logic [11:0] exp;
    exp = frame(8'h3C);
    bus.load_valid = 1'b1;
    bus.load_data  = 8'h3C;
    bus.repeat_cnt = 4'd2;
    @(negedge clk);
    bus.load_valid = 1'b0;
    bus.repeat_cnt = 4'd0;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < FW; i++) begin
        total++;
        if (bus.out_valid !== 1'b1 || bus.sequence_out !== exp[FW-1-i] || bus.done !== 1'b0) begin
          bad++;
          $display("FAIL rep_r%0d_bit%0d: got vld=%b seq=%b done=%b want 1 %b 0",
                   r, i, bus.out_valid, bus.sequence_out, bus.done, exp[FW-1-i]);
        end
        @(negedge clk);
      end
    end
    total++;
    if ({bus.load_ready, bus.out_valid, bus.sequence_out, bus.done} !== 4'b1001) begin
      bad++;
      $display("FAIL rep_done: got rdy/vld/seq/done=%b want 1001",
               {bus.load_ready, bus.out_valid, bus.sequence_out, bus.done});
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic [11:0] exp;
    exp = frame(8'h81);
    bus.load_valid = 1'b1;
    bus.load_data  = 8'h81;
    bus.repeat_cnt = 4'd0;
    @(negedge clk);
    // Second word is offered for the whole first frame.
    bus.load_data = 8'hFF;
    for (int i = 0; i < FW; i++) begin
      total++;
      if (bus.out_valid !== 1'b1 || bus.sequence_out !== exp[FW-1-i] || bus.load_ready !== 1'b0) begin
        bad++;
        $display("FAIL b2b_first_bit%0d: got vld=%b seq=%b rdy=%b want 1 %b 0",
                 i, bus.out_valid, bus.sequence_out, bus.load_ready, exp[FW-1-i]);
      end
      @(negedge clk);
    end
    total++;
    if ({bus.load_ready, bus.out_valid, bus.sequence_out, bus.done} !== 4'b1001) begin
      bad++;
      $display("FAIL b2b_gap: got rdy/vld/seq/done=%b want 1001",
               {bus.load_ready, bus.out_valid, bus.sequence_out, bus.done});
    end
    @(negedge clk);
    bus.load_valid = 1'b0;
    exp = frame(8'hFF);
    for (int i = 0; i < FW; i++) begin
      total++;
      if (bus.out_valid !== 1'b1 || bus.sequence_out !== exp[FW-1-i] || bus.done !== 1'b0) begin
        bad++;
        $display("FAIL b2b_second_bit%0d: got vld=%b seq=%b done=%b want 1 %b 0",
                 i, bus.out_valid, bus.sequence_out, bus.done, exp[FW-1-i]);
      end
      @(negedge clk);
    end
    total++;
    if ({bus.load_ready, bus.out_valid, bus.done} !== 3'b101) begin
      bad++;
      $display("FAIL b2b_done2: got rdy/vld/done=%b want 101",
               {bus.load_ready, bus.out_valid, bus.done});
    end
    @(negedge clk);
    total++;
    if ({bus.load_ready, bus.out_valid, bus.done} !== 3'b100) begin
      bad++;
      $display("FAIL b2b_no_third: got rdy/vld/done=%b want 100",
               {bus.load_ready, bus.out_valid, bus.done});
    end
  endtask

  task automatic test_reset_mid;
    logic [11:0] exp;
    exp = frame(8'hC3);
    bus.load_valid = 1'b1;
    bus.load_data  = 8'hC3;
    bus.repeat_cnt = 4'd1;
    @(negedge clk);
    bus.load_valid = 1'b0;
    bus.repeat_cnt = 4'd0;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (bus.out_valid !== 1'b1 || bus.sequence_out !== exp[FW-1-i]) begin
        bad++;
        $display("FAIL abort_bit%0d: got vld=%b seq=%b want 1 %b",
                 i, bus.out_valid, bus.sequence_out, exp[FW-1-i]);
      end
      if (i < 4) @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++;
    if ({bus.load_ready, bus.out_valid, bus.sequence_out, bus.done} !== 4'b1000) begin
      bad++;
      $display("FAIL abort_reset: got rdy/vld/seq/done=%b want 1000",
               {bus.load_ready, bus.out_valid, bus.sequence_out, bus.done});
    end
    @(negedge clk);
    total++;
    if ({bus.load_ready, bus.out_valid, bus.done} !== 3'b100) begin
      bad++;
      $display("FAIL abort_no_done: got rdy/vld/done=%b want 100",
               {bus.load_ready, bus.out_valid, bus.done});
    end
    exp = frame(8'h01);
    bus.load_valid = 1'b1;
    bus.load_data  = 8'h01;
    @(negedge clk);
    bus.load_valid = 1'b0;
    for (int i = 0; i < FW; i++) begin
      total++;
      if (bus.out_valid !== 1'b1 || bus.sequence_out !== exp[FW-1-i] || bus.done !== 1'b0) begin
        bad++;
        $display("FAIL post_abort_bit%0d: got vld=%b seq=%b done=%b want 1 %b 0",
                 i, bus.out_valid, bus.sequence_out, bus.done, exp[FW-1-i]);
      end
      @(negedge clk);
    end
    total++;
    if ({bus.load_ready, bus.out_valid, bus.sequence_out, bus.done} !== 4'b1001) begin
      bad++;
      $display("FAIL post_abort_done: got rdy/vld/seq/done=%b want 1001",
               {bus.load_ready, bus.out_valid, bus.sequence_out, bus.done});
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_repeat();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
